// File: rtl/controller_interface.sv
// controller_interface
//   Scans two serial game pads that share one latch strobe and one shift clock.
//   A scan pulses ctrl_latch so each pad loads its button state, then clocks
//   the eight bits out MSB-first, inverts them (the pads drive active-low) and
//   publishes both bytes at once with a single-cycle valid pulse.
//
//   Works with pads that load asynchronously while latch is high and with pads
//   that load on a ctrl_clk rising edge while latch is high: the latch window
//   contains exactly one ctrl_clk rising edge.
//
// Parameters
//   HALF_PERIOD  clk cycles per ctrl_clk half period (4..255)
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   request one scan; sampled only while idle
//   data0_B     in   pad 0 serial data, active-low, asynchronous
//   data1_B     in   pad 1 serial data, active-low, asynchronous
//   ctrl_latch  out  latch strobe to both pads (flop output)
//   ctrl_clk    out  shift clock to both pads (flop output)
//   buttons0    out  pad 0 {a,b,select,start,up,down,left,right}, 1 = pressed
//   buttons1    out  pad 1, same encoding
//   valid       out  one-cycle pulse when buttons0/1 update
//   busy        out  high from scan start through the valid cycle
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start
// LATCH    | ctrl_latch=1; first half ctrl_clk=0, second half ctrl_clk=1
// GAP      | latch released; bit 7 sampled on the last cycle
// SHIFT_HI | ctrl_clk=1, pads shift on entry
// SHIFT_LO | ctrl_clk=0; next bit sampled on the last cycle
// DONE     | buttons loaded, valid=1 for one cycle

module controller_interface #(
  parameter int HALF_PERIOD = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       data0_B,
  input  logic       data1_B,
  output logic       ctrl_latch,
  output logic       ctrl_clk,
  output logic [7:0] buttons0,
  output logic [7:0] buttons1,
  output logic       valid,
  output logic       busy
);

  localparam logic [7:0] HP_M1 = 8'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    GAP      = 3'd2,
    SHIFT_HI = 3'd3,
    SHIFT_LO = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t      r_state;
  logic [7:0]  r_phase;
  logic [2:0]  r_bit;
  logic [1:0]  r_sync0;
  logic [1:0]  r_sync1;
  logic [6:0]  r_sh0;
  logic [6:0]  r_sh1;
  logic [7:0]  r_buttons0;
  logic [7:0]  r_buttons1;
  logic        r_ctrl_latch;
  logic        r_ctrl_clk;
  logic        r_valid;
  logic        r_busy;

  state_t      w_state_nxt;
  logic [7:0]  w_phase_nxt;
  logic [2:0]  w_bit_nxt;
  logic        w_phase_tc;
  logic        w_sample;
  logic        w_load;
  logic        w_latch_nxt;
  logic        w_clk_nxt;
  logic        w_valid_nxt;
  logic        w_busy_nxt;
  logic        w_bit0;
  logic        w_bit1;

  assign w_phase_tc = (r_phase == 8'd0);
  assign w_bit0     = ~r_sync0[1];
  assign w_bit1     = ~r_sync1[1];

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_phase <= 8'd0;
      r_bit   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  // Next-state logic. The phase timer counts down to zero; in LATCH the bit
  // counter marks which half of the latch window is running.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_bit_nxt   = r_bit;
    w_sample    = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = LATCH;
          w_phase_nxt = HP_M1;
          w_bit_nxt   = 3'd0;
        end
      end
      LATCH: begin
        if (w_phase_tc) begin
          w_phase_nxt = HP_M1;
          if (r_bit == 3'd0) begin
            w_bit_nxt = 3'd1;
          end else begin
            w_state_nxt = GAP;
            w_bit_nxt   = 3'd0;
          end
        end else begin
          w_phase_nxt = r_phase - 8'd1;
        end
      end
      GAP: begin
        if (w_phase_tc) begin
          w_state_nxt = SHIFT_HI;
          w_phase_nxt = HP_M1;
          w_sample    = 1'b1;
        end else begin
          w_phase_nxt = r_phase - 8'd1;
        end
      end
      SHIFT_HI: begin
        if (w_phase_tc) begin
          w_state_nxt = SHIFT_LO;
          w_phase_nxt = HP_M1;
        end else begin
          w_phase_nxt = r_phase - 8'd1;
        end
      end
      SHIFT_LO: begin
        if (w_phase_tc) begin
          w_sample = 1'b1;
          if (r_bit == 3'd6) begin
            w_state_nxt = DONE;
            w_phase_nxt = 8'd0;
            w_bit_nxt   = 3'd0;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = SHIFT_HI;
            w_phase_nxt = HP_M1;
            w_bit_nxt   = r_bit + 3'd1;
          end
        end else begin
          w_phase_nxt = r_phase - 8'd1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_phase_nxt = 8'd0;
        w_bit_nxt   = 3'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so the pad
  // strobes come straight from flops and line up with the state they belong to.
  always_comb begin
    w_latch_nxt = (w_state_nxt == LATCH);
    w_clk_nxt   = ((w_state_nxt == LATCH) && (w_bit_nxt == 3'd1)) ||
                  (w_state_nxt == SHIFT_HI);
    w_valid_nxt = (w_state_nxt == DONE);
    w_busy_nxt  = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl_latch <= 1'b0;
      r_ctrl_clk   <= 1'b0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_ctrl_latch <= w_latch_nxt;
      r_ctrl_clk   <= w_clk_nxt;
      r_valid      <= w_valid_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Pad inputs idle high (released), so the synchronizers reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync0 <= 2'b11;
      r_sync1 <= 2'b11;
    end else begin
      r_sync0 <= {r_sync0[0], data0_B};
      r_sync1 <= {r_sync1[0], data1_B};
    end
  end

  // Only bits 7..1 are held in the shifters; bit 0 goes straight into the
  // output register on the final sample, so outputs stay frozen mid-scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh0      <= 7'd0;
      r_sh1      <= 7'd0;
      r_buttons0 <= 8'h00;
      r_buttons1 <= 8'h00;
    end else begin
      if (w_sample) begin
        r_sh0 <= {r_sh0[5:0], w_bit0};
        r_sh1 <= {r_sh1[5:0], w_bit1};
      end
      if (w_load) begin
        r_buttons0 <= {r_sh0, w_bit0};
        r_buttons1 <= {r_sh1, w_bit1};
      end
    end
  end

  assign ctrl_latch = r_ctrl_latch;
  assign ctrl_clk   = r_ctrl_clk;
  assign buttons0   = r_buttons0;
  assign buttons1   = r_buttons1;
  assign valid      = r_valid;
  assign busy       = r_busy;

endmodule
